// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding
// and default datapath widths.
package cpu_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_INST_W = 32;

   typedef enum logic [2:0] {
      S_SETTLE  = 3'd0,
      S_REQ     = 3'd1,
      S_ENB     = 3'd2,
      S_WAIT_PC = 3'd3,
      S_HALT    = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bundle: PC register, instruction memory port and
// control-unit instruction handoff.
interface inst_fetch_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int INST_W = DEF_INST_W
);

   logic [ADDR_W-1:0] PC;
   logic              PC_CLK;
   logic [ADDR_W-1:0] IMEM_ADR;
   logic              IMEM_REQ;
   logic              IMEM_ACK;
   logic [INST_W-1:0] IMEM_DATA;
   logic [INST_W-1:0] MEM_INST;
   logic              INST_ENB;
   logic              FETCH_ERR;
   logic              BUSY;

   modport master (
      input  PC, PC_CLK, IMEM_ACK, IMEM_DATA,
      output IMEM_ADR, IMEM_REQ, MEM_INST,
      output INST_ENB, FETCH_ERR, BUSY
   );

   modport slave (
      output PC, PC_CLK, IMEM_ACK, IMEM_DATA,
      input  IMEM_ADR, IMEM_REQ, MEM_INST,
      input  INST_ENB, FETCH_ERR, BUSY
   );

endinterface

// File: rtl/edge_detect.sv
// Registered rising-edge detector with synchronous
// active-low reset.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic din_q;

   always_ff @(posedge clk) begin
      if (!rst_n) din_q <= 1'b0;
      else        din_q <= din;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch sequencer: reads IMEM at PC and strobes
// the word into the control unit once per PC_CLK pulse.
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int INST_W      = DEF_INST_W,
   parameter int ENB_CYCLES  = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input logic          CLK,
   input logic          RST,
   inst_fetch_if.master bus
);

   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
   localparam int ENB_W = $clog2(ENB_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);
   localparam logic [ENB_W-1:0] ENB_MAX = ENB_W'(ENB_CYCLES);

   fetch_state_e      state;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [ENB_W-1:0]  enb_cnt;
   logic              pending;
   logic              pc_edge;
   logic [ADDR_W-1:0] imem_adr;
   logic              imem_req;
   logic [INST_W-1:0] mem_inst;
   logic              inst_enb;
   logic              fetch_err;

   edge_detect u_pc_edge (
      .clk   (CLK),
      .rst_n (RST),
      .din   (bus.PC_CLK),
      .rise  (pc_edge)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= S_SETTLE;
         tmo_cnt   <= '0;
         enb_cnt   <= '0;
         pending   <= 1'b0;
         imem_adr  <= '0;
         imem_req  <= 1'b0;
         mem_inst  <= '0;
         inst_enb  <= 1'b0;
         fetch_err <= 1'b0;
      end else begin
         unique case (state)
            S_SETTLE: begin
               if (bus.PC[1:0] != 2'b00) begin
                  fetch_err <= 1'b1;
                  pending   <= 1'b0;
                  state     <= S_HALT;
               end else begin
                  imem_adr <= bus.PC;
                  imem_req <= 1'b1;
                  tmo_cnt  <= TMO_W'(1);
                  pending  <= pending | pc_edge;
                  state    <= S_REQ;
               end
            end
            S_REQ: begin
               pending <= pending | pc_edge;
               // ACK beats a timeout landing in the same cycle
               if (bus.IMEM_ACK) begin
                  mem_inst <= bus.IMEM_DATA;
                  imem_req <= 1'b0;
                  inst_enb <= 1'b1;
                  enb_cnt  <= ENB_W'(1);
                  state    <= S_ENB;
               end else if (tmo_cnt == TMO_MAX) begin
                  imem_req  <= 1'b0;
                  fetch_err <= 1'b1;
                  state     <= S_HALT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_ENB: begin
               if (enb_cnt == ENB_MAX) begin
                  inst_enb <= 1'b0;
                  pending  <= 1'b0;
                  if (pending | pc_edge) state <= S_SETTLE;
                  else                   state <= S_WAIT_PC;
               end else begin
                  enb_cnt <= enb_cnt + 1'b1;
                  pending <= pending | pc_edge;
               end
            end
            S_WAIT_PC: begin
               if (pc_edge) state <= S_SETTLE;
            end
            S_HALT: begin
               imem_req <= 1'b0;
               inst_enb <= 1'b0;
            end
            default: state <= S_HALT;
         endcase
      end
   end

   assign bus.IMEM_ADR  = imem_adr;
   assign bus.IMEM_REQ  = imem_req;
   assign bus.MEM_INST  = mem_inst;
   assign bus.INST_ENB  = inst_enb;
   assign bus.FETCH_ERR = fetch_err;
   assign bus.BUSY      = (state != S_WAIT_PC) &&
                          (state != S_HALT);

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch sequencer that drives the control unit's instruction input (MEM_INST with the INST_ENB strobe). It reads instruction memory at the current PC and presents each word to the control unit for a fixed strobe window. It then waits for the control unit's PC_CLK pulse before fetching the next word. It sits between the PC register, the instruction memory port and the control unit.

## Interface
Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- INST_W, 32, instruction word width
- ENB_CYCLES, 4, INST_ENB high time in CLK cycles (>=1)
- MEM_TIMEOUT, 255, max cycles IMEM_REQ may wait for IMEM_ACK (>=1)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, synchronous, active-low
- PC  in  ADDR_W  current program counter from PC register
- PC_CLK  in  1  from control unit; rising edge = PC advanced, next instruction wanted
- IMEM_ADR  out  ADDR_W  instruction memory address
- IMEM_REQ  out  1  read request, level, held until ACK
- IMEM_ACK  in  1  one-cycle read acknowledge, IMEM_DATA valid same cycle
- IMEM_DATA  in  INST_W  instruction read data
- MEM_INST  out  INST_W  instruction to control unit
- INST_ENB  out  1  instruction valid strobe to control unit
- FETCH_ERR  out  1  sticky: misaligned PC or memory timeout
- BUSY  out  1  high in every state except WAIT_PC and HALT

## Operation
- States: SETTLE, REQ, ENB, WAIT_PC, HALT.
- Reset (RST=0 at a CLK edge): state=SETTLE; MEM_INST=0, INST_ENB=0, IMEM_REQ=0, IMEM_ADR=0, FETCH_ERR=0, pending=0, counters=0.
- SETTLE: one cycle for PC to update.
  - If PC[1:0]!=0: FETCH_ERR=1, go HALT.
  - Otherwise IMEM_ADR<=PC and go REQ.
- REQ: IMEM_REQ=1 while timeout counter counts.
  - IMEM_ACK=1: MEM_INST<=IMEM_DATA, IMEM_REQ<=0, go ENB.
  - Counter reaches MEM_TIMEOUT without ACK: IMEM_REQ<=0, FETCH_ERR=1, go HALT.
- ENB: INST_ENB=1 for exactly ENB_CYCLES cycles.
  - Then INST_ENB<=0.
  - If pending: clear it, go SETTLE. Otherwise go WAIT_PC.
- WAIT_PC: PC_CLK rising edge goes to SETTLE.
- HALT: all strobes low, MEM_INST held; left only via reset.
- PC_CLK edge detection: registered previous value; edge = PC_CLK & ~PC_CLK_q.
- Edges arriving in SETTLE, REQ or ENB set pending. A single pending bit absorbs multiple edges; extra edges are dropped.
- MEM_INST stays stable from ACK until the next ACK, including during WAIT_PC and HALT.
- IMEM_ADR stays stable throughout REQ.

## Timing
- PC_CLK edge sampled at cycle t (in WAIT_PC): SETTLE at t+1, IMEM_REQ=1 and IMEM_ADR=PC from t+2.
- ACK at cycle a: MEM_INST new and INST_ENB=1 during cycles a+1 .. a+ENB_CYCLES; INST_ENB=0 at a+ENB_CYCLES+1.
- ACK in the first REQ cycle is legal: zero-wait memory gives edge-to-INST_ENB latency of 3 cycles.
- ACK in the same cycle the counter hits MEM_TIMEOUT: ACK wins, no error.
- IMEM_ACK outside REQ is ignored.
- RST low mid-operation: next edge forces the reset values. An in-flight request is abandoned (IMEM_REQ drops immediately).
- After reset release, first fetch request appears on the 2nd cycle (SETTLE, then REQ).

## Structure
- Shared package cpu_pkg holds:
  - fetch state encoding: SETTLE=0, REQ=1, ENB=2, WAIT_PC=3, HALT=4, 3-bit
  - default widths ADDR_W/INST_W
- Sub-module edge_detect (registered rising-edge detector, synchronous active-low reset) for PC_CLK; reusable by other blocks.
- Timeout counter width: clog2(MEM_TIMEOUT+1). ENB counter width: clog2(ENB_CYCLES+1).

## Test plan
- Reset, PC=0, memory returns 32'h06308093 with ACK 2 cycles after REQ -> IMEM_ADR=0, MEM_INST=32'h06308093, INST_ENB high exactly 4 cycles, state WAIT_PC, BUSY=0.
- In WAIT_PC, pulse PC_CLK with PC=4, zero-wait ACK returning 32'h002081b3 -> IMEM_REQ at t+2 with IMEM_ADR=4; INST_ENB rises at t+3.
- PC_CLK edge during ENB, PC=8 -> after the strobe ends, go directly SETTLE/REQ with IMEM_ADR=8, no WAIT_PC visit; a second edge in the same window produces no extra fetch.
- PC=32'h6 after PC_CLK -> FETCH_ERR=1, no IMEM_REQ, HALT; further PC_CLK pulses ignored until RST=0.
- No ACK for 255 cycles -> IMEM_REQ drops, FETCH_ERR=1. Repeat with ACK on cycle 255 -> normal fetch, FETCH_ERR=0.
- RST=0 asserted two cycles into REQ -> next edge: IMEM_REQ=0, MEM_INST=0, FETCH_ERR=0; refetch starts on release.
